// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: arbitrates I/D cache misses onto one memory port (write-back, fill, done).
// Optional watchdog enabled by CACHE_MISS_CTRL_TIMEOUT_EN.
module cache_miss_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_miss,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_dirty,
  input  logic [5:0]        d_victim_tag,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              i_fill,
  output logic              d_fill,
  output logic              wb_sel,
  output logic              i_done,
  output logic              d_done,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;
  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(15);
  state_t r_state;
  logic r_last_d, r_gnt_d, r_mem_req, r_mem_we, r_wb_sel;
  logic r_i_fill, r_d_fill, r_i_done, r_d_done, r_busy;
  logic [ADDR_W-1:0] r_addr, r_mem_addr;
  logic w_gnt_i, w_gnt_d, w_tmo;
  logic [ADDR_W-1:0] w_addr;
  // the round-robin pointer only moves when both requesters contend
  assign w_gnt_i = i_miss && (!d_miss || r_last_d);
  assign w_gnt_d = d_miss && !w_gnt_i;
  assign w_addr  = w_gnt_i ? i_addr : d_addr;
`ifdef CACHE_MISS_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic r_err;
  assign w_tmo = (r_state == WB || r_state == FILL) && !mem_ack && r_cnt == CW'(TIMEOUT - 1);
  assign err = r_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == WB || r_state == FILL) && !mem_ack ? r_cnt + CW'(1) : '0;
      r_err <= r_err | w_tmo;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_d   <= 1'b1;
      r_gnt_d    <= 1'b0;
      r_addr     <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_wb_sel   <= 1'b0;
      r_mem_addr <= '0;
      r_i_fill   <= 1'b0;
      r_d_fill   <= 1'b0;
      r_i_done   <= 1'b0;
      r_d_done   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_i_fill <= 1'b0;
      r_d_fill <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      if (w_tmo) begin
        r_state    <= IDLE;
        r_mem_req  <= 1'b0;
        r_mem_we   <= 1'b0;
        r_wb_sel   <= 1'b0;
        r_mem_addr <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (i_miss || d_miss) begin
            r_gnt_d   <= w_gnt_d;
            r_last_d  <= (i_miss && d_miss) ? w_gnt_d : r_last_d;
            r_addr    <= w_addr & BLK_MASK;
            r_mem_req <= 1'b1;
            r_busy    <= 1'b1;
            if (w_gnt_d && d_dirty) begin
              r_state    <= WB;
              r_mem_we   <= 1'b1;
              r_wb_sel   <= 1'b1;
              r_mem_addr <= ADDR_W'({d_victim_tag, d_addr[9:4], 4'b0});
            end else begin
              r_state    <= FILL;
              r_mem_addr <= w_addr & BLK_MASK;
            end
          end
          WB: if (mem_ack) begin
            r_state    <= FILL;
            r_mem_we   <= 1'b0;
            r_wb_sel   <= 1'b0;
            r_mem_addr <= r_addr;
          end
          FILL: if (mem_ack) begin
            r_state    <= DONE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_i_fill   <= !r_gnt_d;
            r_i_done   <= !r_gnt_d;
            r_d_fill   <= r_gnt_d;
            r_d_done   <= r_gnt_d;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end
  assign mem_req  = r_mem_req;
  assign mem_we   = r_mem_we;
  assign wb_sel   = r_wb_sel;
  assign mem_addr = r_mem_addr;
  assign i_fill   = r_i_fill;
  assign d_fill   = r_d_fill;
  assign i_done   = r_i_done;
  assign d_done   = r_d_done;
  assign busy     = r_busy;
endmodule

// File: doc/cache_miss_ctrl.md
CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: byte-word address width; block offset is bits [3:0], index is bits [9:4], tag is bits [15:10].
REQ-002 Parameter TIMEOUT, default 64: watchdog limit in cycles (used only with CACHE_MISS_CTRL_TIMEOUT_EN).
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Ports i_miss / d_miss  input  1 each: instruction-cache / data-cache miss request; level, held until the matching done pulse.
REQ-006 Ports i_addr / d_addr  input  ADDR_W each: missing address from each requester.
REQ-007 Ports d_dirty  input  1 and d_victim_tag  input  6: the victim line in the data cache is dirty; the victim line's tag.
REQ-008 Ports mem_req, mem_we  output  1 each, and mem_addr  output  ADDR_W: shared main-memory block request, write-enable, and block address (bits [3:0] always 0).
REQ-009 Port mem_ack  input  1: memory completes the current block transfer; ignored while mem_req=0.
REQ-010 Ports i_fill, d_fill  output  1 each: one-cycle pulse loading the 256-bit memory block into the I-cache or D-cache line (D fill also clears the dirty bit and sets valid).
REQ-011 Port wb_sel  output  1: routes the D-cache victim block onto the memory write bus; high throughout the write-back phase.
REQ-012 Ports i_done, d_done  output  1 each: one-cycle miss-complete pulse; busy  output  1: controller not in IDLE; err  output  1: timeout flag.

Function
REQ-013 The FSM SHALL have states IDLE, WB, FILL, DONE.
REQ-014 In IDLE, a pending miss is granted: if only one is pending, that requester wins; if both are pending, the requester not granted last wins (round-robin); last_grant resets to D, so I wins the first tie.
REQ-015 At grant, the controller latches requester ID, address, dirty and victim tag; later input changes do not affect the transaction in flight.
REQ-016 A D grant with d_dirty=1 goes to WB; any other grant goes to FILL.
REQ-017 WB: mem_req=1, mem_we=1, wb_sel=1, mem_addr={victim_tag, index, 4'b0}; on mem_ack go to FILL.
REQ-018 FILL: mem_req=1, mem_we=0, mem_addr={latched addr[15:4], 4'b0}; on mem_ack go to DONE.
REQ-019 DONE (exactly one cycle): pulse i_fill+i_done or d_fill+d_done for the granted requester, then IDLE; the requester drops miss on the edge at which done is sampled.
REQ-020 Latency with zero-wait mem_ack: a clean miss sampled in cycle N gives done in N+2; a dirty miss gives done in N+3; each memory wait cycle adds one.
REQ-021 mem_req stays high and mem_addr stays stable from phase entry until mem_ack; a new miss arriving mid-transaction waits in IDLE arbitration.
REQ-022 Outputs not driven by the current state are 0.

Reset
REQ-023 Reset asserted at any time, including mid-WB or mid-FILL, forces within the same cycle: state=IDLE, last_grant=D, and mem_req, mem_we, wb_sel, i_fill, d_fill, i_done, d_done, busy, err=0, mem_addr=0; an interrupted transaction is dropped with no fill or done pulse.

Configuration
REQ-024 With CACHE_MISS_CTRL_TIMEOUT_EN defined, a cycle counter clears on every WB/FILL entry; if it reaches TIMEOUT without mem_ack, err latches to 1 (cleared only by reset), the FSM returns to IDLE, and no fill or done pulse occurs. Without the macro, there is no counter, err is tied to 0, and the FSM waits indefinitely.

Verification
REQ-025 i_miss=1, i_addr=16'h8A37, mem_ack on the first req cycle -> mem_addr=16'h8A30, mem_we=0, i_fill+i_done two cycles after the sample.
REQ-026 d_miss=1, d_dirty=1, d_victim_tag=6'h05, d_addr=16'h1234 -> WB with mem_addr=16'h1630, mem_we=1, wb_sel=1; then FILL with mem_addr=16'h1230; then d_fill+d_done.
REQ-027 i_miss and d_miss rise together twice after reset -> grant order I, D, then D, I (round-robin continues).
REQ-028 Reset pulse during FILL with mem_ack held low -> all outputs 0 immediately; no fill or done pulse; the next miss is serviced normally.
REQ-029 mem_ack delayed by 5 cycles -> mem_req and mem_addr are stable for all 6 cycles; done is delayed by 5.
REQ-030 With the macro defined, TIMEOUT=8, and mem_ack never asserted -> err=1 after 8 FILL cycles, busy=0, no i_done.
